// File: rtl/sys_result_collector_if.sv
// rtl/sys_result_collector_if.sv - result stream, readout port and status bundle of the result collector
interface sys_result_collector_if #(
  parameter int DW = 16
);
  logic          start;
  logic          relu_en;
  logic          res_sig;
  logic [DW-1:0] result;
  logic          rd_en;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_last;
  logic [7:0]    o_row;
  logic [7:0]    o_col;
  logic          busy;
  logic          done;
  logic          err;

  modport slave (
    input  start, relu_en, res_sig, result, rd_en,
    output o_data, o_valid, o_last, o_row, o_col, busy, done, err
  );

  modport master (
    output start, relu_en, res_sig, result, rd_en,
    input  o_data, o_valid, o_last, o_row, o_col, busy, done, err
  );
endinterface

// File: rtl/sys_result_collector.sv
// rtl/sys_result_collector.sv - buffers one OUT_DIM x OUT_DIM result map (optional ReLU) and streams it out in raster order
module sys_result_collector #(
  parameter int SIZE = 14,
  parameter int K    = 3,
  parameter int DW   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sys_result_collector_if.slave bus
);
  localparam int OUT_DIM = SIZE - K + 1;
  localparam int DEPTH   = OUT_DIM * OUT_DIM;
  localparam int PW      = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, COLLECT, READ} state_t;

  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [7:0]    row;
  logic [7:0]    col;
  logic          relu;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_last;
  logic          busy;
  logic          done;
  logic          err;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] wdata;
  logic          col_wrap;

  // ReLU only looks at the sign bit; the word is otherwise stored as received.
  assign wdata    = (relu && bus.result[DW-1]) ? '0 : bus.result;
  assign col_wrap = (col == 8'(OUT_DIM - 1));

  always_ff @(posedge clk) begin
    if (state == COLLECT && bus.res_sig) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      row     <= '0;
      col     <= '0;
      relu    <= 1'b0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            // A result arriving alongside start is dropped but still flagged.
            relu   <= bus.relu_en;
            err    <= bus.res_sig;
            wr_ptr <= '0;
            row    <= '0;
            col    <= '0;
            busy   <= 1'b1;
            state  <= COLLECT;
          end else if (bus.res_sig) begin
            err <= 1'b1;
          end
        end
        COLLECT: begin
          if (bus.res_sig) begin
            if (wr_ptr == PW'(DEPTH - 1)) begin
              wr_ptr <= '0;
              rd_ptr <= '0;
              row    <= '0;
              col    <= '0;
              done   <= 1'b1;
              state  <= READ;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
              col    <= col_wrap ? 8'd0 : col + 8'd1;
              row    <= col_wrap ? row + 8'd1 : row;
            end
          end
        end
        READ: begin
          if (bus.res_sig) begin
            err <= 1'b1;
          end
          if (bus.rd_en) begin
            o_data  <= mem[rd_ptr];
            o_valid <= 1'b1;
            if (rd_ptr == PW'(DEPTH - 1)) begin
              // The final word still pulses out next cycle, already in IDLE.
              o_last <= 1'b1;
              rd_ptr <= '0;
              row    <= '0;
              col    <= '0;
              busy   <= 1'b0;
              done   <= 1'b0;
              state  <= IDLE;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
              col    <= col_wrap ? 8'd0 : col + 8'd1;
              row    <= col_wrap ? row + 8'd1 : row;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_data  = o_data;
  assign bus.o_valid = o_valid;
  assign bus.o_last  = o_last;
  assign bus.o_row   = row;
  assign bus.o_col   = col;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.err     = err;
endmodule
